// File: rtl/apb_regfile_ctrl.sv
// APB slave register file for the CatRecognizer datapath: CTRL/STATUS pair plus pixel/weight
// storage, with programmable wait states, slave error and an independent core read port.
module apb_regfile_ctrl #(
  parameter int Amba_Word       = 24,
  parameter int Amba_Addr_Depth = 13,
  parameter int Wait_States     = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [Amba_Addr_Depth:0]   PADDR,
  input  logic [Amba_Word-1:0]       PWDATA,
  output logic [Amba_Word-1:0]       PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  input  logic [Amba_Addr_Depth-1:0] core_addr,
  output logic [Amba_Word-1:0]       core_rdata,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic                       core_result
);

  localparam int         Depth    = 2 ** Amba_Addr_Depth;
  localparam logic [1:0] WaitLoad = 2'(Wait_States);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               r_state, w_next_state;
  logic [1:0]           r_cnt, w_next_cnt;
  logic [Amba_Word-1:0] r_mem [Depth];
  logic [Amba_Word-1:0] r_prdata, r_core_rdata, w_rdata;
  logic                 r_pready, r_pslverr, r_start;
  logic                 r_busy, r_done, r_result;

  logic w_oor, w_is_ctrl, w_is_status, w_is_mem, w_err, w_load_resp;
  logic w_commit, w_ctrl_wr, w_start, w_clear, w_mem_wr, w_done_ev;

  assign w_oor       = PADDR[Amba_Addr_Depth];
  assign w_is_ctrl   = (PADDR == '0);
  assign w_is_status = (PADDR == (Amba_Addr_Depth+1)'(1));
  assign w_is_mem    = !w_oor && !w_is_ctrl && !w_is_status;

  assign w_err = w_oor
               | (PWRITE & w_is_status)
               | (PWRITE & w_is_ctrl & PWDATA[0] & r_busy)
               | (PWRITE & w_is_mem & r_busy);

  always_comb begin
    w_rdata = '0;
    if (!PWRITE && !w_err) begin
      if (w_is_status) begin
        w_rdata[2:0] = {r_result, r_done, r_busy};
      end else if (w_is_mem) begin
        w_rdata = r_mem[PADDR[Amba_Addr_Depth-1:0]];
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (PSEL && !PENABLE) w_next_state = SETUP;
      end
      SETUP: begin
        if (PSEL) begin
          w_next_state = ACCESS;
          w_next_cnt   = WaitLoad;
        end else begin
          w_next_state = IDLE;
        end
      end
      ACCESS: begin
        if (r_cnt != 2'd0) begin
          if (!PSEL) w_next_state = IDLE;
          else       w_next_cnt   = r_cnt - 2'd1;
        end else if (PSEL && !PENABLE) begin
          w_next_state = SETUP;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Response registers are loaded one cycle ahead so they line up with the ready cycle.
  assign w_load_resp = (w_next_state == ACCESS) && (w_next_cnt == 2'd0);

  assign w_commit  = r_pready & ~r_pslverr & PWRITE;
  assign w_ctrl_wr = w_commit & w_is_ctrl;
  assign w_start   = w_ctrl_wr & PWDATA[0];
  assign w_clear   = w_ctrl_wr & PWDATA[1];
  assign w_mem_wr  = w_commit & w_is_mem;
  assign w_done_ev = core_done & r_busy;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_pready     <= 1'b0;
      r_pslverr    <= 1'b0;
      r_prdata     <= '0;
      r_start      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= 1'b0;
      r_core_rdata <= '0;
    end else begin
      r_state      <= w_next_state;
      r_cnt        <= w_next_cnt;
      r_pready     <= w_load_resp;
      r_pslverr    <= w_load_resp & w_err;
      r_prdata     <= w_load_resp ? w_rdata : '0;
      r_start      <= w_start;
      r_core_rdata <= r_mem[core_addr];
      if (w_start)        r_busy <= 1'b1;
      else if (w_done_ev) r_busy <= 1'b0;
      // A completion in the same cycle as a clear leaves done set.
      if (w_done_ev)                r_done <= 1'b1;
      else if (w_start || w_clear)  r_done <= 1'b0;
      if (w_done_ev) r_result <= core_result;
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_wr) r_mem[PADDR[Amba_Addr_Depth-1:0]] <= PWDATA;
  end

  assign PRDATA     = r_prdata;
  assign PREADY     = r_pready;
  assign PSLVERR    = r_pslverr;
  assign core_rdata = r_core_rdata;
  assign core_start = r_start;

endmodule

// File: tb/tb_apb_regfile_ctrl.sv
// Directed bench for apb_regfile_ctrl: three instances with 0, 2 and 3 wait states
// driven by independent APB masters.
module tb_apb_regfile_ctrl;

  logic        clock;
  logic        resetN;
  logic        psel       [3];
  logic        penable    [3];
  logic        pwrite     [3];
  logic [13:0] paddr      [3];
  logic [23:0] pwdata     [3];
  logic [23:0] prdata     [3];
  logic        pready     [3];
  logic        pslverr    [3];
  logic [12:0] coreAddr   [3];
  logic [23:0] coreRdata  [3];
  logic        coreStart  [3];
  logic        coreDone   [3];
  logic        coreResult [3];

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          waits;
  logic [23:0] rd;
  logic        er;

  apb_regfile_ctrl #(.Amba_Word(24), .Amba_Addr_Depth(13), .Wait_States(0)) uWs0 (
    .clock(clock), .reset(resetN), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
    .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PRDATA(prdata[0]), .PREADY(pready[0]),
    .PSLVERR(pslverr[0]), .core_addr(coreAddr[0]), .core_rdata(coreRdata[0]),
    .core_start(coreStart[0]), .core_done(coreDone[0]), .core_result(coreResult[0]));

  apb_regfile_ctrl #(.Amba_Word(24), .Amba_Addr_Depth(13), .Wait_States(2)) uWs2 (
    .clock(clock), .reset(resetN), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
    .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PRDATA(prdata[1]), .PREADY(pready[1]),
    .PSLVERR(pslverr[1]), .core_addr(coreAddr[1]), .core_rdata(coreRdata[1]),
    .core_start(coreStart[1]), .core_done(coreDone[1]), .core_result(coreResult[1]));

  apb_regfile_ctrl #(.Amba_Word(24), .Amba_Addr_Depth(13), .Wait_States(3)) uWs3 (
    .clock(clock), .reset(resetN), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
    .PADDR(paddr[2]), .PWDATA(pwdata[2]), .PRDATA(prdata[2]), .PREADY(pready[2]),
    .PSLVERR(pslverr[2]), .core_addr(coreAddr[2]), .core_rdata(coreRdata[2]),
    .core_start(coreStart[2]), .core_done(coreDone[2]), .core_result(coreResult[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
    end
  endtask

  // One complete APB transfer; optionally pulses core_done in the commit cycle.
  task automatic applyStimulus(input int k, input logic wr, input logic [13:0] addr,
                               input logic [23:0] wdata, input logic doneAtCommit,
                               output logic [23:0] rdata, output logic err, output int nWaits);
    @(negedge clock);
    psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wdata;
    @(negedge clock);
    penable[k] = 1'b1;
    nWaits = 0;
    @(negedge clock);
    while (!pready[k] && nWaits < 16) begin
      nWaits++;
      @(negedge clock);
    end
    checkOutput("pready_seen", {31'd0, pready[k]}, 32'd1);
    rdata = prdata[k];
    err   = pslverr[k];
    if (doneAtCommit) begin
      coreDone[k] = 1'b1; coreResult[k] = 1'b0;
    end
    @(posedge clock); #1;
    psel[k] = 1'b0; penable[k] = 1'b0; coreDone[k] = 1'b0;
  endtask

  initial begin
    resetN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = '0; pwdata[i] = '0;
      coreAddr[i] = '0; coreDone[i] = 0; coreResult[i] = 0;
    end
    repeat (2) @(negedge clock);
    checkOutput("rst_prdata", {8'd0, prdata[0]}, 32'd0);
    checkOutput("rst_pready", {31'd0, pready[0]}, 32'd0);
    checkOutput("rst_pslverr", {31'd0, pslverr[0]}, 32'd0);
    checkOutput("rst_core_start", {31'd0, coreStart[0]}, 32'd0);
    checkOutput("rst_core_rdata", {8'd0, coreRdata[0]}, 32'd0);
    resetN = 1'b1;

    // Zero wait states: basic write/read
    applyStimulus(0, 1, 14'd2, 24'hA5A5A5, 0, rd, er, waits);
    checkOutput("ws0_wr2_err", {31'd0, er}, 32'd0);
    applyStimulus(0, 0, 14'd2, 24'h0, 0, rd, er, waits);
    checkOutput("ws0_rd2_data", {8'd0, rd}, 32'hA5A5A5);
    checkOutput("ws0_rd2_err", {31'd0, er}, 32'd0);
    checkOutput("ws0_rd2_waits", waits, 32'd0);

    // Core port read-during-write returns the old word, then the new one
    coreAddr[0] = 13'd2;
    applyStimulus(0, 1, 14'd2, 24'h0F0F0F, 0, rd, er, waits);
    checkOutput("rdw_old", {8'd0, coreRdata[0]}, 32'hA5A5A5);
    @(posedge clock); #1;
    checkOutput("rdw_new", {8'd0, coreRdata[0]}, 32'h0F0F0F);

    // Start, busy protection, completion
    applyStimulus(0, 1, 14'd3, 24'h123456, 0, rd, er, waits);
    applyStimulus(0, 1, 14'd0, 24'h000001, 0, rd, er, waits);
    checkOutput("start_err", {31'd0, er}, 32'd0);
    checkOutput("start_pulse_hi", {31'd0, coreStart[0]}, 32'd1);
    @(posedge clock); #1;
    checkOutput("start_pulse_lo", {31'd0, coreStart[0]}, 32'd0);
    applyStimulus(0, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("status_busy", {8'd0, rd}, 32'd1);
    applyStimulus(0, 1, 14'd3, 24'hFFFFFF, 0, rd, er, waits);
    checkOutput("wr_busy_err", {31'd0, er}, 32'd1);
    applyStimulus(0, 1, 14'd0, 24'h000001, 0, rd, er, waits);
    checkOutput("restart_busy_err", {31'd0, er}, 32'd1);
    applyStimulus(0, 0, 14'd3, 24'h0, 0, rd, er, waits);
    checkOutput("addr3_kept", {8'd0, rd}, 32'h123456);
    @(negedge clock); coreDone[0] = 1; coreResult[0] = 1;
    @(negedge clock); coreDone[0] = 0; coreResult[0] = 0;
    applyStimulus(0, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("status_done_res", {8'd0, rd}, 32'd6);

    // Clear-done racing a completion, then a plain clear
    applyStimulus(0, 1, 14'd0, 24'h000001, 0, rd, er, waits);
    applyStimulus(0, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("status_restart", {8'd0, rd}, 32'd5);
    applyStimulus(0, 1, 14'd0, 24'h000002, 1, rd, er, waits);
    checkOutput("clr_race_err", {31'd0, er}, 32'd0);
    applyStimulus(0, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("clr_race_status", {8'd0, rd}, 32'd2);
    applyStimulus(0, 1, 14'd0, 24'h000002, 0, rd, er, waits);
    applyStimulus(0, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("clr_status", {8'd0, rd}, 32'd0);

    // Error responses and idle core_done
    applyStimulus(0, 1, 14'h2000, 24'h777777, 0, rd, er, waits);
    checkOutput("oor_wr_err", {31'd0, er}, 32'd1);
    applyStimulus(0, 0, 14'h2000, 24'h0, 0, rd, er, waits);
    checkOutput("oor_rd_err", {31'd0, er}, 32'd1);
    checkOutput("oor_rd_data", {8'd0, rd}, 32'd0);
    applyStimulus(0, 1, 14'd1, 24'h000007, 0, rd, er, waits);
    checkOutput("status_wr_err", {31'd0, er}, 32'd1);
    @(negedge clock); coreDone[0] = 1; coreResult[0] = 1;
    @(negedge clock); coreDone[0] = 0; coreResult[0] = 0;
    applyStimulus(0, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("status_unchanged", {8'd0, rd}, 32'd0);
    applyStimulus(0, 0, 14'd0, 24'h0, 0, rd, er, waits);
    checkOutput("ctrl_reads_zero", {8'd0, rd}, 32'd0);

    // Two wait states
    applyStimulus(1, 1, 14'd5, 24'h5A5A5A, 0, rd, er, waits);
    checkOutput("ws2_wr_waits", waits, 32'd2);
    applyStimulus(1, 0, 14'd5, 24'h0, 0, rd, er, waits);
    checkOutput("ws2_rd_waits", waits, 32'd2);
    checkOutput("ws2_rd_data", {8'd0, rd}, 32'h5A5A5A);
    @(negedge clock); coreAddr[1] = 13'd5;
    @(negedge clock);
    checkOutput("ws2_core_rd", {8'd0, coreRdata[1]}, 32'h5A5A5A);

    // Abort by dropping PSEL during wait states
    applyStimulus(1, 1, 14'd6, 24'h111111, 0, rd, er, waits);
    @(negedge clock);
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 14'd6; pwdata[1] = 24'h222222;
    @(negedge clock); penable[1] = 1;
    @(negedge clock);
    checkOutput("abort_ready_a", {31'd0, pready[1]}, 32'd0);
    psel[1] = 0; penable[1] = 0;
    repeat (3) @(negedge clock);
    checkOutput("abort_ready_b", {31'd0, pready[1]}, 32'd0);
    applyStimulus(1, 0, 14'd6, 24'h0, 0, rd, er, waits);
    checkOutput("abort_no_write", {8'd0, rd}, 32'h111111);

    // Reset in the middle of a three-wait-state access
    applyStimulus(2, 1, 14'd4, 24'hC0FFEE, 0, rd, er, waits);
    applyStimulus(2, 1, 14'd0, 24'h000001, 0, rd, er, waits);
    applyStimulus(2, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("ws3_status_busy", {8'd0, rd}, 32'd1);
    checkOutput("ws3_waits", waits, 32'd3);
    @(negedge clock);
    psel[2] = 1; penable[2] = 0; pwrite[2] = 0; paddr[2] = 14'd4;
    @(negedge clock); penable[2] = 1;
    @(negedge clock);
    #2 resetN = 1'b0;
    #1;
    checkOutput("midrst_pready", {31'd0, pready[2]}, 32'd0);
    checkOutput("midrst_prdata", {8'd0, prdata[2]}, 32'd0);
    @(negedge clock);
    psel[2] = 0; penable[2] = 0;
    resetN = 1'b1;
    applyStimulus(2, 0, 14'd1, 24'h0, 0, rd, er, waits);
    checkOutput("postrst_status", {8'd0, rd}, 32'd0);
    applyStimulus(2, 0, 14'd4, 24'h0, 0, rd, er, waits);
    checkOutput("postrst_data", {8'd0, rd}, 32'hC0FFEE);
    checkOutput("postrst_err", {31'd0, er}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
